// File: rtl/t08_lcd_cmd_seq.sv
// rtl/t08_lcd_cmd_seq.sv - LCD power-up and rectangle-fill command sequencer feeding the 8080-style bus driver
module t08_lcd_cmd_seq #(
  parameter int unsigned DELAY_CYCLES = 1200000,
  parameter int unsigned PIX_W        = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start_init,
  output logic             init_done,
  input  logic             fill_req,
  input  logic [PIX_W-1:0] fill_x0,
  input  logic [PIX_W-1:0] fill_x1,
  input  logic [PIX_W-1:0] fill_y0,
  input  logic [PIX_W-1:0] fill_y1,
  input  logic [PIX_W-1:0] fill_color,
  output logic             fill_ready,
  output logic             fill_done,
  output logic             fill_err,
  output logic [31:0]      spi_inputs,
  output logic             spi_enable_command,
  output logic             spi_enable_parameter,
  output logic             spi_readwrite,
  input  logic             spi_busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_PARAM,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_DELAY
  } state_t;

  localparam logic [2:0] STEP_SWRESET = 3'd0;
  localparam logic [2:0] STEP_SLPOUT  = 3'd1;
  localparam logic [2:0] STEP_COLMOD  = 3'd2;
  localparam logic [2:0] STEP_DISPON  = 3'd3;
  localparam logic [2:0] STEP_CASET   = 3'd4;
  localparam logic [2:0] STEP_RASET   = 3'd5;
  localparam logic [2:0] STEP_PIXEL   = 3'd6;

  // DELAY lasts load+1 cycles, so loading N-1 gives exactly N idle clocks
  localparam logic [23:0] DLY_LOAD = 24'(DELAY_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [23:0]      dly_q, dly_d;
  logic [31:0]      words_q, words_d;
  logic             first_q, first_d;
  logic [PIX_W-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d, color_q, color_d;
  logic             init_done_q, init_done_d;
  logic             fill_done_q, fill_done_d;
  logic             fill_err_q, fill_err_d;
  logic [31:0]      spi_data_q, spi_data_d;

  logic [PIX_W:0]   win_w, win_h;
  logic [31:0]      pix_count;
  logic [31:0]      pix_words;
  logic             cmd_only;
  logic             bad_bounds;
  logic [7:0]       cmd_byte;

  // Window size and number of two-pixel parameter words for the latched fill
  always_comb begin
    win_w     = {1'b0, x1_q} - {1'b0, x0_q} + 1'b1;
    win_h     = {1'b0, y1_q} - {1'b0, y0_q} + 1'b1;
    pix_count = 32'(win_w) * 32'(win_h);
    pix_words = 32'((33'(pix_count) + 33'd1) >> 1);
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      step_q      <= STEP_SWRESET;
      dly_q       <= '0;
      words_q     <= '0;
      first_q     <= 1'b0;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
      init_done_q <= 1'b0;
      fill_done_q <= 1'b0;
      fill_err_q  <= 1'b0;
      spi_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      dly_q       <= dly_d;
      words_q     <= words_d;
      first_q     <= first_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      color_q     <= color_d;
      init_done_q <= init_done_d;
      fill_done_q <= fill_done_d;
      fill_err_q  <= fill_err_d;
      spi_data_q  <= spi_data_d;
    end
  end

  // Next-state: transaction handshake, step sequencing and bus word selection
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    dly_d       = dly_q;
    words_d     = words_q;
    first_d     = first_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    color_d     = color_q;
    init_done_d = init_done_q;
    fill_done_d = 1'b0;
    fill_err_d  = 1'b0;
    spi_data_d  = spi_data_q;
    cmd_byte    = 8'h00;

    cmd_only   = (step_q == STEP_SWRESET) || (step_q == STEP_SLPOUT) || (step_q == STEP_DISPON);
    bad_bounds = (fill_x1 < fill_x0) || (fill_y1 < fill_y0);

    case (state_q)
      ST_IDLE: begin
        // Launch goes through a zero-length DELAY so the first command still waits for an idle bus
        if (start_init) begin
          init_done_d = 1'b0;
          step_d      = STEP_SWRESET;
          dly_d       = '0;
          state_d     = ST_DELAY;
        end else if (fill_req && init_done_q) begin
          x0_d    = fill_x0;
          x1_d    = fill_x1;
          y0_d    = fill_y0;
          y1_d    = fill_y1;
          color_d = fill_color;
          if (bad_bounds) begin
            fill_err_d = 1'b1;
          end else begin
            step_d  = STEP_CASET;
            dly_d   = '0;
            state_d = ST_DELAY;
          end
        end
      end
      ST_CMD:     state_d = cmd_only ? ST_WAIT_HI : ST_PARAM;
      ST_PARAM:   state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (spi_busy) state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!spi_busy) begin
          case (step_q)
            STEP_SWRESET: begin
              step_d  = STEP_SLPOUT;
              dly_d   = DLY_LOAD;
              state_d = ST_DELAY;
            end
            STEP_SLPOUT: begin
              step_d  = STEP_COLMOD;
              dly_d   = DLY_LOAD;
              state_d = ST_DELAY;
            end
            STEP_COLMOD: begin
              step_d  = STEP_DISPON;
              state_d = ST_CMD;
            end
            STEP_DISPON: begin
              init_done_d = 1'b1;
              state_d     = ST_IDLE;
            end
            STEP_CASET: begin
              step_d  = STEP_RASET;
              state_d = ST_CMD;
            end
            STEP_RASET: begin
              step_d  = STEP_PIXEL;
              first_d = 1'b1;
              words_d = pix_words;
              state_d = ST_CMD;
            end
            STEP_PIXEL: begin
              if (words_q <= 32'd1) begin
                fill_done_d = 1'b1;
                state_d     = ST_IDLE;
              end else begin
                words_d = words_q - 32'd1;
                first_d = 1'b0;
                state_d = ST_CMD;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_DELAY: begin
        if (dly_q != '0) begin
          dly_d = dly_q - 24'd1;
        end else if (!spi_busy) begin
          state_d = ST_CMD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (step_d)
      STEP_SWRESET: cmd_byte = 8'h01;
      STEP_SLPOUT:  cmd_byte = 8'h11;
      STEP_COLMOD:  cmd_byte = 8'h3A;
      STEP_DISPON:  cmd_byte = 8'h29;
      STEP_CASET:   cmd_byte = 8'h2A;
      STEP_RASET:   cmd_byte = 8'h2B;
      STEP_PIXEL:   cmd_byte = first_d ? 8'h2C : 8'h3C;
      default:      cmd_byte = 8'h00;
    endcase

    // Bus word is registered alongside the strobe so it holds between transactions
    if (state_d == ST_CMD) begin
      spi_data_d = {24'b0, cmd_byte};
    end else if (state_d == ST_PARAM) begin
      case (step_d)
        STEP_COLMOD: spi_data_d = 32'h0000_0055;
        STEP_CASET:  spi_data_d = {x0_q, x1_q};
        STEP_RASET:  spi_data_d = {y0_q, y1_q};
        STEP_PIXEL:  spi_data_d = {color_q, color_q};
        default:     spi_data_d = spi_data_q;
      endcase
    end
  end

  // Outputs decoded from the current state and registered flags
  always_comb begin
    spi_enable_command   = (state_q == ST_CMD);
    spi_enable_parameter = (state_q == ST_PARAM);
    spi_readwrite        = 1'b1;
    spi_inputs           = spi_data_q;
    init_done            = init_done_q;
    fill_ready           = init_done_q && (state_q == ST_IDLE);
    fill_done            = fill_done_q;
    fill_err             = fill_err_q;
  end

endmodule

// File: tb/tb_t08_lcd_cmd_seq.sv
// tb/tb_t08_lcd_cmd_seq.sv - self-checking bench for t08_lcd_cmd_seq
module tb_t08_lcd_cmd_seq;

  localparam int DLY = 10;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start_init;
  logic        init_done;
  logic        fill_req;
  logic [15:0] fill_x0, fill_x1, fill_y0, fill_y1, fill_color;
  logic        fill_ready, fill_done, fill_err;
  logic [31:0] spi_inputs;
  logic        spi_enable_command, spi_enable_parameter, spi_readwrite;
  logic        spi_busy;

  always #5 clk = ~clk;

  t08_lcd_cmd_seq #(.DELAY_CYCLES(DLY), .PIX_W(16)) dut (
    .clk                  (clk),
    .nrst                 (nrst),
    .start_init           (start_init),
    .init_done            (init_done),
    .fill_req             (fill_req),
    .fill_x0              (fill_x0),
    .fill_x1              (fill_x1),
    .fill_y0              (fill_y0),
    .fill_y1              (fill_y1),
    .fill_color           (fill_color),
    .fill_ready           (fill_ready),
    .fill_done            (fill_done),
    .fill_err             (fill_err),
    .spi_inputs           (spi_inputs),
    .spi_enable_command   (spi_enable_command),
    .spi_enable_parameter (spi_enable_parameter),
    .spi_readwrite        (spi_readwrite),
    .spi_busy             (spi_busy)
  );

  typedef struct {
    bit          is_cmd;
    logic [31:0] d;
  } xact_t;

  typedef struct {
    logic [15:0] x0, x1, y0, y1, c;
    bit          exp_err;
    int          exp_words;
  } vec_t;

  xact_t log_q[$];
  int    log_cyc[$];
  xact_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    err_cnt = 0;
  int    busy_cnt = 0;
  bit    rand_busy = 0;
  bit    rw_low = 0;

  // Driver model: busy rises after the last strobe of each transaction, plus the strobe log
  initial begin
    spi_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy_cnt > 0) begin
        spi_busy = 1'b1;
        busy_cnt--;
      end else begin
        spi_busy = 1'b0;
      end
      if (spi_enable_command) begin
        log_q.push_back('{1'b1, spi_inputs});
        log_cyc.push_back(cyc);
        if (spi_inputs == 32'h01 || spi_inputs == 32'h11 || spi_inputs == 32'h29)
          busy_cnt = rand_busy ? int'($urandom_range(1, 6)) : 8;
      end
      if (spi_enable_parameter) begin
        log_q.push_back('{1'b0, spi_inputs});
        log_cyc.push_back(cyc);
        busy_cnt = rand_busy ? int'($urandom_range(1, 6)) : 8;
      end
      if (fill_done) done_cnt++;
      if (fill_err) err_cnt++;
      if (spi_readwrite !== 1'b1) rw_low = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_log(input string name);
    int bad_idx;
    int n;
    chk({name, "_len"}, 64'(log_q.size()), 64'(exp_q.size()));
    bad_idx = -1;
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (bad_idx < 0 && (log_q[i].is_cmd !== exp_q[i].is_cmd || log_q[i].d !== exp_q[i].d))
        bad_idx = i;
    n_cmp++;
    if (bad_idx >= 0) begin
      n_bad++;
      $display("FAIL %s_seq: entry %0d got cmd=%0b %08h expected cmd=%0b %08h", name, bad_idx,
               log_q[bad_idx].is_cmd, log_q[bad_idx].d, exp_q[bad_idx].is_cmd, exp_q[bad_idx].d);
    end
  endtask

  task automatic model_init();
    exp_q.delete();
    exp_q.push_back('{1'b1, 32'h01});
    exp_q.push_back('{1'b1, 32'h11});
    exp_q.push_back('{1'b1, 32'h3A});
    exp_q.push_back('{1'b0, 32'h55});
    exp_q.push_back('{1'b1, 32'h29});
  endtask

  // Reference: window commands then ceil(pixels/2) colour words, 2C first and 3C after
  task automatic model_fill(input logic [15:0] x0, x1, y0, y1, c, output bit err, output int words);
    longint cnt;
    exp_q.delete();
    err = (x1 < x0) || (y1 < y0);
    words = 0;
    if (!err) begin
      cnt = (longint'(x1) - longint'(x0) + 1) * (longint'(y1) - longint'(y0) + 1);
      words = int'((cnt + 1) / 2);
      exp_q.push_back('{1'b1, 32'h2A});
      exp_q.push_back('{1'b0, {x0, x1}});
      exp_q.push_back('{1'b1, 32'h2B});
      exp_q.push_back('{1'b0, {y0, y1}});
      for (int i = 0; i < words; i++) begin
        exp_q.push_back('{1'b1, (i == 0) ? 32'h2C : 32'h3C});
        exp_q.push_back('{1'b0, {c, c}});
      end
    end
  endtask

  task automatic pulse_fill(input logic [15:0] x0, x1, y0, y1, c);
    @(negedge clk);
    fill_x0 = x0; fill_x1 = x1; fill_y0 = y0; fill_y1 = y1; fill_color = c;
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  task automatic wait_fill_end(input string name, input int d0, input int e0);
    int k;
    k = 0;
    while (done_cnt == d0 && err_cnt == e0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no fill_done/fill_err in %0d cycles, required one", name, k);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_init(input string name);
    int k;
    k = 0;
    while (init_done !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got init_done=%0b, required 1", name, init_done);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_fill(input string name, input logic [15:0] x0, x1, y0, y1, c,
                          output bit got_err, output int got_words);
    int  d0, e0;
    bit  m_err;
    int  m_words;
    log_q.delete();
    log_cyc.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_fill(x0, x1, y0, y1, c);
    wait_fill_end(name, d0, e0);
    model_fill(x0, x1, y0, y1, c, m_err, m_words);
    cmp_log(name);
    chk({name, "_done"}, 64'(done_cnt - d0), m_err ? 64'd0 : 64'd1);
    chk({name, "_err"}, 64'(err_cnt - e0), m_err ? 64'd1 : 64'd0);
    chk({name, "_ready"}, 64'(fill_ready), 64'd1);
    got_err = (err_cnt - e0) != 0;
    got_words = 0;
    foreach (log_q[i]) if (!log_q[i].is_cmd) got_words++;
    if (got_words >= 2) got_words -= 2;
  endtask

  vec_t tbl[7];

  initial begin
    bit          g_err;
    int          g_words;
    int          d0, e0, k;
    logic [15:0] rx0, rx1, ry0, ry1;

    tbl[0] = '{16'd10, 16'd11, 16'd20, 16'd21, 16'hF800, 1'b0, 2};
    tbl[1] = '{16'd5, 16'd5, 16'd0, 16'd2, 16'h1234, 1'b0, 2};
    tbl[2] = '{16'd9, 16'd3, 16'd0, 16'd0, 16'h07E0, 1'b1, 0};
    tbl[3] = '{16'd0, 16'd0, 16'd7, 16'd2, 16'h001F, 1'b1, 0};
    tbl[4] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF, 1'b0, 1};
    tbl[5] = '{16'd100, 16'd103, 16'd50, 16'd50, 16'hABCD, 1'b0, 2};
    tbl[6] = '{16'd7, 16'd9, 16'd1, 16'd3, 16'h5A5A, 1'b0, 5};

    nrst = 1'b0;
    start_init = 1'b0;
    fill_req = 1'b0;
    fill_x0 = '0; fill_x1 = '0; fill_y0 = '0; fill_y1 = '0; fill_color = '0;
    repeat (3) @(negedge clk);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_fill_ready", 64'(fill_ready), 64'd0);
    chk("rst_spi_inputs", 64'(spi_inputs), 64'd0);
    chk("rst_strobes", 64'({spi_enable_command, spi_enable_parameter}), 64'd0);
    chk("rst_readwrite", 64'(spi_readwrite), 64'd1);
    chk("rst_done_err", 64'({fill_done, fill_err}), 64'd0);
    nrst = 1'b1;

    // fill before init is dropped silently
    log_q.delete();
    pulse_fill(16'd1, 16'd2, 16'd1, 16'd2, 16'h1111);
    repeat (20) @(negedge clk);
    chk("preinit_strobes", 64'(log_q.size()), 64'd0);
    chk("preinit_err", 64'(err_cnt), 64'd0);

    // power-up sequence
    log_q.delete();
    log_cyc.delete();
    @(negedge clk); start_init = 1'b1;
    @(negedge clk); start_init = 1'b0;
    wait_init("init");
    model_init();
    cmp_log("init");
    if (log_cyc.size() >= 3) begin
      chk("gap_after_01", 64'((log_cyc[1] - log_cyc[0]) >= 8 + DLY), 64'd1);
      chk("gap_after_11", 64'((log_cyc[2] - log_cyc[1]) >= 8 + DLY), 64'd1);
    end
    chk("init_done", 64'(init_done), 64'd1);
    chk("init_fill_ready", 64'(fill_ready), 64'd1);

    // table of fills
    for (int i = 0; i < 7; i++) begin
      run_fill($sformatf("vec%0d", i), tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1, tbl[i].c,
               g_err, g_words);
      chk($sformatf("vec%0d_errflag", i), 64'(g_err), 64'(tbl[i].exp_err));
      chk($sformatf("vec%0d_words", i), 64'(g_words), 64'(tbl[i].exp_words));
      if (i == 0) begin
        chk("vec0_caset", 64'(log_q[1].d), 64'h000A000B);
        chk("vec0_raset", 64'(log_q[3].d), 64'h00140015);
        chk("vec0_ramwr", 64'(log_q[4].d), 64'h2C);
        chk("vec0_wrcont", 64'(log_q[6].d), 64'h3C);
      end
    end

    // second request during an active fill is dropped
    log_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_fill(16'd0, 16'd3, 16'd0, 16'd1, 16'hC0DE);
    repeat (6) @(negedge clk);
    pulse_fill(16'd50, 16'd60, 16'd5, 16'd9, 16'hBEEF);
    wait_fill_end("drop", d0, e0);
    model_fill(16'd0, 16'd3, 16'd0, 16'd1, 16'hC0DE, g_err, g_words);
    cmp_log("drop");
    chk("drop_done", 64'(done_cnt - d0), 64'd1);
    repeat (20) @(negedge clk);
    chk("drop_no_second", 64'(done_cnt - d0), 64'd1);

    // randomized fills against the reference model, random busy lengths
    rand_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx0 = 16'($urandom_range(1, 300));
      ry0 = 16'($urandom_range(1, 200));
      rx1 = ($urandom_range(0, 9) == 0) ? rx0 - 16'd1 : rx0 + 16'($urandom_range(0, 5));
      ry1 = ($urandom_range(0, 9) == 0) ? ry0 - 16'd1 : ry0 + 16'($urandom_range(0, 3));
      run_fill($sformatf("rnd%0d", i), rx0, rx1, ry0, ry1, 16'($urandom), g_err, g_words);
    end
    rand_busy = 1'b0;

    // reset while waiting after the 2B parameter
    log_q.delete();
    d0 = done_cnt;
    pulse_fill(16'd0, 16'd99, 16'd0, 16'd99, 16'h1234);
    k = 0;
    while (log_q.size() < 4 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_reached_2b", 64'(log_q.size() >= 4), 64'd1);
    nrst = 1'b0;
    @(negedge clk);
    chk("rst_mid_strobes", 64'({spi_enable_command, spi_enable_parameter}), 64'd0);
    chk("rst_mid_init_done", 64'(init_done), 64'd0);
    chk("rst_mid_fill_ready", 64'(fill_ready), 64'd0);
    chk("rst_mid_spi_inputs", 64'(spi_inputs), 64'd0);
    chk("rst_mid_readwrite", 64'(spi_readwrite), 64'd1);
    nrst = 1'b1;
    log_q.delete();
    repeat (20) @(negedge clk);
    pulse_fill(16'd1, 16'd2, 16'd1, 16'd2, 16'h2222);
    repeat (20) @(negedge clk);
    chk("rst_mid_silent", 64'(log_q.size()), 64'd0);
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);

    // start_init and fill_req together: init wins
    log_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    start_init = 1'b1;
    fill_req = 1'b1;
    fill_x0 = 16'd3; fill_x1 = 16'd4; fill_y0 = 16'd3; fill_y1 = 16'd4;
    @(negedge clk);
    start_init = 1'b0;
    fill_req = 1'b0;
    wait_init("reinit");
    model_init();
    cmp_log("reinit");
    chk("reinit_no_fill", 64'(done_cnt - d0 + err_cnt - e0), 64'd0);
    chk("readwrite_held", 64'(rw_low), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
